mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared definitions for the instruction/data bus arbiter
package mem_bus_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } arb_state_e;

  // Bus geometry and timeout defaults
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT    = 255;

  // Wait counter width and the byte-lane mask used for instruction fetches
  localparam int         WAIT_CNT_W = 8;
  localparam logic [3:0] SEL_ALL    = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fixed-priority fetch/load-store arbiter onto one shared bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_stall_request,
  input  logic                  mem_req,
  input  logic                  mem_write_en,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_stall_request,
  input  logic                  flush,
  output logic                  bus_en,
  output logic                  bus_write_en,
  output logic [3:0]            bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  input  logic [DATA_WIDTH-1:0] bus_read_data,
  input  logic                  bus_ready,
  output logic                  bus_error
);

  // Timeout limit widened by one bit so the compare against cnt+1 never wraps
  localparam logic [WAIT_CNT_W:0] TIMEOUT_LIM = (WAIT_CNT_W + 1)'(TIMEOUT);

  arb_state_e              state_q;
  logic [WAIT_CNT_W-1:0]   cnt_q;
  logic                    flush_seen_q;
  logic                    bus_en_q;
  logic                    bus_write_en_q;
  logic [3:0]              bus_sel_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_write_data_q;
  logic                    if_ack_q;
  logic                    mem_ack_q;
  logic [DATA_WIDTH-1:0]   if_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_rdata_q;
  logic                    bus_error_q;

  logic                    timeout_hit;
  logic                    if_cancel;

  // A wait cycle that would bring the counter to TIMEOUT ends the transaction;
  // a fetch is cancelled if flush was seen during it or arrives on its final edge
  always_comb begin
    timeout_hit = ({1'b0, cnt_q} + 1'b1) >= TIMEOUT_LIM;
    if_cancel   = flush_seen_q | flush;
  end

  // Arbitration FSM with wait counter, bus drive and read-data capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      flush_seen_q     <= 1'b0;
      bus_en_q         <= 1'b0;
      bus_write_en_q   <= 1'b0;
      bus_sel_q        <= '0;
      bus_addr_q       <= '0;
      bus_write_data_q <= '0;
      if_ack_q         <= 1'b0;
      mem_ack_q        <= 1'b0;
      if_rdata_q       <= '0;
      mem_rdata_q      <= '0;
      bus_error_q      <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Data side has priority; a requester being acked this cycle is not regranted
          if (mem_req && !mem_ack_q) begin
            state_q          <= ST_BUSY_MEM;
            cnt_q            <= '0;
            bus_en_q         <= 1'b1;
            bus_write_en_q   <= mem_write_en;
            bus_sel_q        <= mem_sel;
            bus_addr_q       <= mem_addr;
            bus_write_data_q <= mem_wdata;
          end else if (if_req && !if_ack_q && !flush) begin
            state_q          <= ST_BUSY_IF;
            cnt_q            <= '0;
            flush_seen_q     <= 1'b0;
            bus_en_q         <= 1'b1;
            bus_write_en_q   <= 1'b0;
            bus_sel_q        <= SEL_ALL;
            bus_addr_q       <= if_addr;
            bus_write_data_q <= '0;
          end
        end
        ST_BUSY_IF: begin
          if (bus_ready || timeout_hit) begin
            state_q  <= ST_IDLE;
            bus_en_q <= 1'b0;
            if (!if_cancel) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus_ready ? bus_read_data : '0;
            end
            if (!bus_ready) begin
              bus_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (flush) begin
              flush_seen_q <= 1'b1;
            end
          end
        end
        ST_BUSY_MEM: begin
          if (bus_ready || timeout_hit) begin
            state_q     <= ST_IDLE;
            bus_en_q    <= 1'b0;
            mem_ack_q   <= 1'b1;
            mem_rdata_q <= bus_ready ? bus_read_data : '0;
            if (!bus_ready) begin
              bus_error_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          bus_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and combinational stall requests
  always_comb begin
    bus_en            = bus_en_q;
    bus_write_en      = bus_write_en_q;
    bus_sel           = bus_sel_q;
    bus_addr          = bus_addr_q;
    bus_write_data    = bus_write_data_q;
    if_ack            = if_ack_q;
    mem_ack           = mem_ack_q;
    if_rdata          = if_rdata_q;
    mem_rdata         = mem_rdata_q;
    bus_error         = bus_error_q;
    if_stall_request  = if_req & ~if_ack_q;
    mem_stall_request = mem_req & ~mem_ack_q;
  end

endmodule
